dqn_predictor_bank: RTL and testbench
=====================================

Name: dqn_predictor_bank

Overview:
- Parametrised, time-multiplexed successor to the single-tap delay/sign-XOR/coefficient-update/trigger/delay chain of the ADPCM zero predictor.
- Holds an NTAPS-deep delay line of floating-point quantized differences (DQn) and NTAPS predictor coefficients (Bn).
- Updates one tap per cycle under a start/busy/done handshake, then shifts the delay line.
- Sits between the quantizer/float-converter and the predictor multiply-accumulate.

Parameters:
- NTAPS, 6, number of zero-predictor taps (2..16).
- DQN_W, 11, float DQn width: [10] sign, [9:6] exponent, [5:0] mantissa.
- DQ_W, 16, sign-magnitude DQ width, sign at MSB.
- B_W, 16, two's-complement coefficient width.
- DQN_RST, 32, reset value of every delay-line entry.

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  request one update sweep; accepted only when idle
- dq  in  DQ_W  current quantized difference, sampled on accepted start
- dqn_in  in  DQN_W  float DQ pushed into delay line at sweep end, sampled on start
- rate  in  2  coding rate; 2'b11 = 40 kbit/s
- tr  in  1  transition-detect trigger, sampled on start
- busy  out  1  sweep in progress
- done  out  1  one-cycle sweep-complete pulse
- tap_valid  out  1  tap_* outputs valid this cycle
- tap_idx  out  4  tap index being updated
- tap_dqn  out  DQN_W  DQn of that tap (pre-shift)
- tap_b  out  B_W  updated coefficient of that tap

Behaviour:
- Reset (synchronous, high): state IDLE; all delay entries = DQN_RST; all coefficients = 0; busy, done, tap_valid, tap_idx, tap_dqn, tap_b = 0. Reset mid-sweep aborts it: no done, no partial shift retained.
- FSM states:
  - IDLE -> UPDATE on start (latch dq, dqn_in, rate, tr; idx = 0).
  - UPDATE: one tap per cycle, idx 0..NTAPS-1; -> SHIFT after idx = NTAPS-1.
  - SHIFT -> IDLE.
- busy = 1 in UPDATE and SHIFT. start while busy is ignored, not queued.
- Per UPDATE cycle, tap i:
  - Sign/step:
    - U = dq[DQ_W-1] XOR dqn[i][DQN_W-1].
    - UGB = 0 if dq magnitude == 0; else -128 if U, else +128.
    - LEAK = B[i] >>> 9 if rate == 2'b11, else B[i] >>> 8 (arithmetic shift).
  - Update and trigger:
    - BNP = B[i] - LEAK + UGB, computed at B_W+2 bits, then wrapped to B_W.
    - B[i] <= tr ? 0 : BNP.
  - Registered outputs, valid the cycle after the update: tap_valid = 1, tap_idx = i, tap_dqn = dqn[i], tap_b = new B[i].
- SHIFT: dqn[k] <= dqn[k-1] for k = NTAPS-1..1; dqn[0] <= latched dqn_in.
- done: registered, high exactly one cycle, the cycle after SHIFT (state IDLE). A start in the done cycle is accepted.
- Timing: start sampled at edge E0; tap_valid high for NTAPS cycles; done high after edge E0+NTAPS+1.
- tr = 1 zeroes all NTAPS coefficients in that sweep. The delay line still shifts.
- dq = 0 or -0 (magnitude 0): UGB = 0; leakage still applied.

Optional Feature:
- Macro: DQNPRED_SAT_EN.
- Defined: BNP is clamped to [-(2^(B_W-1)), 2^(B_W-1)-1] before the tr mux. Saturation also pulses an extra output sat_flag (1 bit) in the same cycle as tap_valid.
- Undefined: BNP wraps modulo 2^B_W; sat_flag port absent.

Test Plan:
1. Reset, then start with dq = 16'h0000, rate = 0, tr = 0, dqn_in = 11'h045 -> six tap_valid cycles, tap_b = 0 and tap_dqn = 32 each. done after edge E0+7. Next sweep shows tap_dqn[0] = 11'h045, taps 1..5 = 32.
2. From B = 0, two sweeps with dq = 16'h0010, dqn_in = 11'h020 (sign 0) -> all taps B = 128, then 256.
3. From B = 256, dq = 16'h8010 (negative, U = 1), rate = 0 -> B = 256 - 1 - 128 = 127 on all taps.
4. B = 512, dq = 0: rate = 2'b11 -> 511; rate = 2'b00 -> 510.
5. B nonzero, start with tr = 1 -> all tap_b = 0, delay line shifted, done pulses.
6. start pulsed while busy -> ignored, single done. Reset asserted at tap 3 -> no done; B = 0, dqn = 32 everywhere. With DQNPRED_SAT_EN, B_W = 8, B = 127, UGB = +128 -> tap_b = 127 and sat_flag = 1.

Source files
------------

// File: rtl/dqn_predictor_bank.sv
// dqn_predictor_bank: NTAPS-deep DQn delay line plus NTAPS zero-predictor
// coefficients. A start request runs one sweep that updates one coefficient
// per cycle (sign-XOR step, leakage, transition trigger), then shifts the
// delay line and pushes the latched dqn_in into entry 0.
// Optional feature macro: DQNPRED_SAT_EN (clamp BNP and add sat_flag output).
module dqn_predictor_bank #(
  parameter int NTAPS   = 6,
  parameter int DQN_W   = 11,
  parameter int DQ_W    = 16,
  parameter int B_W     = 16,
  parameter int DQN_RST = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DQ_W-1:0]  dq,
  input  logic [DQN_W-1:0] dqn_in,
  input  logic [1:0]       rate,
  input  logic             tr,
  output logic             busy,
  output logic             done,
  output logic             tap_valid,
  output logic [3:0]       tap_idx,
  output logic [DQN_W-1:0] tap_dqn,
  output logic [B_W-1:0]   tap_b
`ifdef DQNPRED_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_UPDATE = 2'b01,
    ST_SHIFT  = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [DQN_W-1:0] dqn_r [NTAPS];
  logic [B_W-1:0]   b_r   [NTAPS];

  logic [DQ_W-1:0]  dq_lat_r;
  logic [DQN_W-1:0] dqn_in_lat_r;
  logic [1:0]       rate_lat_r;
  logic             tr_lat_r;
  logic [3:0]       idx_r;

  logic [B_W-1:0]   cur_b_s;
  logic [DQN_W-1:0] cur_dqn_s;
  logic             last_tap_s;
  logic             u_s;
  logic             mag_zero_s;
  logic [B_W-1:0]   bnp_s;
  logic [B_W-1:0]   b_new_s;

`ifdef DQNPRED_SAT_EN
  // Clamp bounds and step size at the widened B_W+2 precision.
  localparam logic signed [B_W+1:0] B_MAX   = $signed({3'b000, {(B_W-1){1'b1}}});
  localparam logic signed [B_W+1:0] B_MIN   = $signed({3'b111, {(B_W-1){1'b0}}});
  localparam logic signed [B_W+1:0] UGB_MAG = $signed({{(B_W-6){1'b0}}, 8'h80});
  logic signed [B_W+1:0] b_ext_s;
  logic signed [B_W+1:0] leak_s;
  logic signed [B_W+1:0] ugb_s;
  logic signed [B_W+1:0] bnp_wide_s;
  logic                  sat_s;
`else
  // Wrapping build: modulo 2^B_W arithmetic yields the same low bits as
  // the widened sum, so the datapath stays B_W wide.
  localparam logic signed [B_W-1:0] UGB_MAG = $signed({{(B_W-8){1'b0}}, 8'h80});
  logic signed [B_W-1:0] leak_s;
  logic signed [B_W-1:0] ugb_s;
`endif

  assign last_tap_s = (idx_r == 4'(NTAPS - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (last_tap_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_UPDATE;
        end
      end
      ST_SHIFT: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Select the coefficient and delay entry addressed by the tap index.
  always_comb begin
    cur_b_s   = '0;
    cur_dqn_s = '0;
    for (int i = 0; i < NTAPS; i++) begin
      cur_b_s   = cur_b_s   | ({B_W{idx_r == 4'(i)}}   & b_r[i]);
      cur_dqn_s = cur_dqn_s | ({DQN_W{idx_r == 4'(i)}} & dqn_r[i]);
    end
  end

  // Coefficient update: leakage, sign-driven step, optional clamp, trigger.
  always_comb begin
    u_s        = dq_lat_r[DQ_W-1] ^ cur_dqn_s[DQN_W-1];
    mag_zero_s = (dq_lat_r[DQ_W-2:0] == '0);
`ifdef DQNPRED_SAT_EN
    b_ext_s = $signed({{2{cur_b_s[B_W-1]}}, cur_b_s});
    if (rate_lat_r == 2'b11) begin
      leak_s = b_ext_s >>> 4'd9;
    end else begin
      leak_s = b_ext_s >>> 4'd8;
    end
    if (mag_zero_s) begin
      ugb_s = '0;
    end else if (u_s) begin
      ugb_s = -UGB_MAG;
    end else begin
      ugb_s = UGB_MAG;
    end
    bnp_wide_s = b_ext_s - leak_s + ugb_s;
    if (bnp_wide_s > B_MAX) begin
      bnp_s = B_MAX[B_W-1:0];
      sat_s = 1'b1;
    end else if (bnp_wide_s < B_MIN) begin
      bnp_s = B_MIN[B_W-1:0];
      sat_s = 1'b1;
    end else begin
      bnp_s = bnp_wide_s[B_W-1:0];
      sat_s = 1'b0;
    end
`else
    if (rate_lat_r == 2'b11) begin
      leak_s = $signed(cur_b_s) >>> 4'd9;
    end else begin
      leak_s = $signed(cur_b_s) >>> 4'd8;
    end
    if (mag_zero_s) begin
      ugb_s = '0;
    end else if (u_s) begin
      ugb_s = -UGB_MAG;
    end else begin
      ugb_s = UGB_MAG;
    end
    bnp_s = cur_b_s - leak_s + ugb_s;
`endif
    if (tr_lat_r) begin
      b_new_s = '0;
    end else begin
      b_new_s = bnp_s;
    end
  end

  // Sweep datapath: input latching, per-tap writeback, shift, outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        dqn_r[i] <= DQN_W'(DQN_RST);
        b_r[i]   <= '0;
      end
      dq_lat_r     <= '0;
      dqn_in_lat_r <= '0;
      rate_lat_r   <= 2'b00;
      tr_lat_r     <= 1'b0;
      idx_r        <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tap_valid    <= 1'b0;
      tap_idx      <= 4'd0;
      tap_dqn      <= '0;
      tap_b        <= '0;
`ifdef DQNPRED_SAT_EN
      sat_flag     <= 1'b0;
`endif
    end else begin
      busy      <= (state_nxt_s != ST_IDLE);
      done      <= (state_r == ST_SHIFT);
      tap_valid <= (state_r == ST_UPDATE);
`ifdef DQNPRED_SAT_EN
      sat_flag  <= (state_r == ST_UPDATE) && sat_s;
`endif
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dq_lat_r     <= dq;
            dqn_in_lat_r <= dqn_in;
            rate_lat_r   <= rate;
            tr_lat_r     <= tr;
            idx_r        <= 4'd0;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < NTAPS; i++) begin
            if (idx_r == 4'(i)) begin
              b_r[i] <= b_new_s;
            end
          end
          tap_idx <= idx_r;
          tap_dqn <= cur_dqn_s;
          tap_b   <= b_new_s;
          idx_r   <= idx_r + 4'd1;
        end
        ST_SHIFT: begin
          dqn_r[0] <= dqn_in_lat_r;
          for (int k = 1; k < NTAPS; k++) begin
            dqn_r[k] <= dqn_r[k-1];
          end
          idx_r <= 4'd0;
        end
        default: begin
          idx_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dqn_predictor_bank.sv
// Directed self-checking bench for dqn_predictor_bank (default parameters).
module tb_dqn_predictor_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dq;
  logic [10:0] dqn_in;
  logic [1:0]  rate;
  logic        tr;
  logic        busy;
  logic        done;
  logic        tap_valid;
  logic [3:0]  tap_idx;
  logic [10:0] tap_dqn;
  logic [15:0] tap_b;
`ifdef DQNPRED_SAT_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  dqn_predictor_bank dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dq        (dq),
    .dqn_in    (dqn_in),
    .rate      (rate),
    .tr        (tr),
    .busy      (busy),
    .done      (done),
    .tap_valid (tap_valid),
    .tap_idx   (tap_idx),
    .tap_dqn   (tap_dqn),
    .tap_b     (tap_b)
`ifdef DQNPRED_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0]  cap_idx [0:15];
  logic [10:0] cap_dqn [0:15];
  logic [15:0] cap_b   [0:15];
  int          cap_n;
  int          done_at;
  int          done_cnt;
  logic        busy_c1, busy_c6, busy_c7;

  // Runs one sweep starting at edge E0 and records 16 cycles of outputs.
  // Inputs are inverted after E0 so only the latched values may matter.
  // extra >= 1 re-asserts start so that it is sampled at edge E0+extra.
  task automatic run_sweep(input logic [15:0] d, input logic [10:0] dn,
                           input logic [1:0] r, input logic t, input int extra);
    for (int i = 0; i < 16; i++) begin
      cap_idx[i] = 'x;
      cap_dqn[i] = 'x;
      cap_b[i]   = 'x;
    end
    cap_n = 0; done_at = -1; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; dq = d; dqn_in = dn; rate = r; tr = t;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == extra) ? 1'b1 : 1'b0;
      dq = ~d; dqn_in = ~dn; rate = ~r; tr = ~t;
      @(posedge clk);
      #1;
      if (tap_valid) begin
        if (cap_n < 16) begin
          cap_idx[cap_n] = tap_idx;
          cap_dqn[cap_n] = tap_dqn;
          cap_b[cap_n]   = tap_b;
        end
        cap_n++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 1) busy_c1 = busy;
      if (c == 6) busy_c6 = busy;
      if (c == 7) busy_c7 = busy;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; dq = 16'h0000; dqn_in = 11'h000; rate = 2'b00; tr = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (tap_valid !== 1'b0) begin failures++; $display("FAIL reset_tap_valid got=%b exp=0", tap_valid); end
    checks++; if (tap_idx !== 4'd0) begin failures++; $display("FAIL reset_tap_idx got=%h exp=0", tap_idx); end
    checks++; if (tap_dqn !== 11'h000) begin failures++; $display("FAIL reset_tap_dqn got=%h exp=0", tap_dqn); end
    checks++; if (tap_b !== 16'h0000) begin failures++; $display("FAIL reset_tap_b got=%h exp=0", tap_b); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_sweep();
    run_sweep(16'h0000, 11'h045, 2'b00, 1'b0, -1);
    checks++; if (cap_n !== 6) begin failures++; $display("FAIL first_tap_count got=%0d exp=6", cap_n); end
    checks++; if (done_at !== 7) begin failures++; $display("FAIL first_done_time got=%0d exp=7", done_at); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL first_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL first_busy_c1 got=%b exp=1", busy_c1); end
    checks++; if (busy_c6 !== 1'b1) begin failures++; $display("FAIL first_busy_c6 got=%b exp=1", busy_c6); end
    checks++; if (busy_c7 !== 1'b0) begin failures++; $display("FAIL first_busy_c7 got=%b exp=0", busy_c7); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_idx[i] !== 4'(i)) begin failures++; $display("FAIL first_idx[%0d] got=%h exp=%0d", i, cap_idx[i], i); end
      checks++; if (cap_dqn[i] !== 11'd32) begin failures++; $display("FAIL first_dqn[%0d] got=%h exp=020", i, cap_dqn[i]); end
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL first_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
  endtask

  task automatic test_positive_step();
    logic [10:0] exp_dqn [0:5];
    exp_dqn = '{11'h045, 11'd32, 11'd32, 11'd32, 11'd32, 11'd32};
    run_sweep(16'h0010, 11'h020, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_dqn[i] !== exp_dqn[i]) begin failures++; $display("FAIL pos1_dqn[%0d] got=%h exp=%h", i, cap_dqn[i], exp_dqn[i]); end
      checks++; if (cap_b[i] !== 16'd128) begin failures++; $display("FAIL pos1_b[%0d] got=%h exp=0080", i, cap_b[i]); end
    end
    exp_dqn = '{11'h020, 11'h045, 11'd32, 11'd32, 11'd32, 11'd32};
    run_sweep(16'h0010, 11'h020, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_dqn[i] !== exp_dqn[i]) begin failures++; $display("FAIL pos2_dqn[%0d] got=%h exp=%h", i, cap_dqn[i], exp_dqn[i]); end
      checks++; if (cap_b[i] !== 16'd256) begin failures++; $display("FAIL pos2_b[%0d] got=%h exp=0100", i, cap_b[i]); end
    end
  endtask

  task automatic test_negative_step();
    // 256 - 1 - 128 = 127; 127 - 0 - 128 = -1; -1 - (-1) + 0 = 0
    run_sweep(16'h8010, 11'h020, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== 16'd127) begin failures++; $display("FAIL neg1_b[%0d] got=%h exp=007f", i, cap_b[i]); end
    end
    run_sweep(16'h8010, 11'h020, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== 16'hFFFF) begin failures++; $display("FAIL neg2_b[%0d] got=%h exp=ffff", i, cap_b[i]); end
    end
    run_sweep(16'h8000, 11'h020, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL neg3_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
  endtask

  task automatic test_leak_rate();
    logic [15:0] exp_b [0:7];
    logic [15:0] dqs   [0:7];
    logic [1:0]  rts   [0:7];
    exp_b = '{16'd128, 16'd256, 16'd384, 16'd512, 16'd511, 16'd510, 16'd509, 16'd508};
    dqs   = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
    rts   = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01};
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int s = 0; s < 8; s++) begin
      run_sweep(dqs[s], 11'h020, rts[s], 1'b0, -1);
      for (int i = 0; i < 6; i++) begin
        checks++; if (cap_b[i] !== exp_b[s]) begin failures++; $display("FAIL leak%0d_b[%0d] got=%h exp=%h", s, i, cap_b[i], exp_b[s]); end
      end
    end
  endtask

  task automatic test_sign_mix();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    run_sweep(16'h0000, 11'h420, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL mix0_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
    run_sweep(16'h0010, 11'h020, 2'b00, 1'b0, -1);
    checks++; if (cap_dqn[0] !== 11'h420) begin failures++; $display("FAIL mix1_dqn[0] got=%h exp=420", cap_dqn[0]); end
    checks++; if (cap_b[0] !== 16'hFF80) begin failures++; $display("FAIL mix1_b[0] got=%h exp=ff80", cap_b[0]); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (cap_b[i] !== 16'h0080) begin failures++; $display("FAIL mix1_b[%0d] got=%h exp=0080", i, cap_b[i]); end
    end
  endtask

  task automatic test_trigger();
    logic [10:0] exp_dqn [0:5];
    exp_dqn = '{11'h020, 11'h420, 11'd32, 11'd32, 11'd32, 11'd32};
    run_sweep(16'h0010, 11'h011, 2'b00, 1'b1, -1);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL trig_done_count got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_dqn[i] !== exp_dqn[i]) begin failures++; $display("FAIL trig_dqn[%0d] got=%h exp=%h", i, cap_dqn[i], exp_dqn[i]); end
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL trig_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
    exp_dqn = '{11'h011, 11'h020, 11'h420, 11'd32, 11'd32, 11'd32};
    run_sweep(16'h0000, 11'h030, 2'b00, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_dqn[i] !== exp_dqn[i]) begin failures++; $display("FAIL trig_shift_dqn[%0d] got=%h exp=%h", i, cap_dqn[i], exp_dqn[i]); end
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL trig_after_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
  endtask

  task automatic test_busy_ignored();
    logic [15:0] exp_b [0:5];
    exp_b = '{16'h0080, 16'h0080, 16'h0080, 16'hFF80, 16'h0080, 16'h0080};
    run_sweep(16'h0010, 11'h040, 2'b00, 1'b0, 3);
    checks++; if (cap_n !== 6) begin failures++; $display("FAIL busy_tap_count got=%0d exp=6", cap_n); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL busy_b[%0d] got=%h exp=%h", i, cap_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_b   [0:5];
    logic [10:0] exp_dqn [0:5];
    exp_b   = '{16'h0080, 16'h0080, 16'h0080, 16'hFF81, 16'h0080, 16'h0080};
    exp_dqn = '{11'h050, 11'h040, 11'h030, 11'h011, 11'h020, 11'h420};
    // Second start lands in the done cycle with inverted inputs: tr = 1.
    run_sweep(16'h0000, 11'h050, 2'b00, 1'b0, 8);
    checks++; if (cap_n !== 12) begin failures++; $display("FAIL b2b_tap_count got=%0d exp=12", cap_n); end
    checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    checks++; if (done_at !== 7) begin failures++; $display("FAIL b2b_done_time got=%0d exp=7", done_at); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_first_b[%0d] got=%h exp=%h", i, cap_b[i], exp_b[i]); end
      checks++; if (cap_dqn[i+6] !== exp_dqn[i]) begin failures++; $display("FAIL b2b_second_dqn[%0d] got=%h exp=%h", i, cap_dqn[i+6], exp_dqn[i]); end
      checks++; if (cap_b[i+6] !== 16'h0000) begin failures++; $display("FAIL b2b_second_b[%0d] got=%h exp=0000", i, cap_b[i+6]); end
    end
  endtask

  task automatic test_reset_abort();
    int late_done;
    // Line is [7AF,050,040,030,011,020]: tap0 negative -> B = -128, others +128.
    run_sweep(16'h0010, 11'h060, 2'b00, 1'b0, -1);
    checks++; if (cap_b[0] !== 16'hFF80) begin failures++; $display("FAIL abort_pre_b[0] got=%h exp=ff80", cap_b[0]); end
    checks++; if (cap_b[5] !== 16'h0080) begin failures++; $display("FAIL abort_pre_b[5] got=%h exp=0080", cap_b[5]); end
    @(negedge clk);
    start = 1'b1; dq = 16'h0010; dqn_in = 11'h070; rate = 2'b00; tr = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (tap_valid !== 1'b0) begin failures++; $display("FAIL abort_tap_valid got=%b exp=0", tap_valid); end
    @(negedge clk); reset = 1'b0;
    late_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) late_done++;
    end
    checks++; if (late_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", late_done); end
    run_sweep(16'h0000, 11'h020, 2'b00, 1'b0, -1);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL abort_after_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_dqn[i] !== 11'd32) begin failures++; $display("FAIL abort_dqn[%0d] got=%h exp=020", i, cap_dqn[i]); end
      checks++; if (cap_b[i] !== 16'h0000) begin failures++; $display("FAIL abort_b[%0d] got=%h exp=0000", i, cap_b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_positive_step();
    test_negative_step();
    test_leak_rate();
    test_sign_mix();
    test_trigger();
    test_busy_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
